collide_stream: RTL and testbench
=================================

Name: collide_stream

Overview:
- Sequential, multi-channel successor to the combinational grid collision check.
- Streams an occupancy grid in chunkWidth-bit beats instead of taking the full gridWidth bitmap at once.
- Each beat's agent footprints for agentNum candidate poses are ANDed against the matching obstacle chunk, which is read from external obstacle RAM.
- Reports a sticky per-channel collide flag and the first colliding beat index. Sits between the PRM edge/pose generator and the obstacle map RAM.

Parameters:
- gridWidth, 65536, total grid bits; must be a multiple of chunkWidth with gridWidth/chunkWidth >= 2.
- chunkWidth, 512, bits per beat.
- agentNum, 4, parallel footprint channels checked per pass.
- Derived: beatNum = gridWidth/chunkWidth; beatW = clog2(beatNum).

Ports:
- CLK  in  1  system clock
- RST  in  1  reset
- start_valid  in  1  request a new check pass
- start_ready  out  1  high only in IDLE
- agent_valid  in  1  agent beat valid
- agent_ready  out  1  high in RUN/FLUSH
- agent_data  in  agentNum*chunkWidth  channel i at bits [i*chunkWidth +: chunkWidth]
- obs_rd_en  out  1  obstacle RAM read strobe
- obs_addr  out  beatW  obstacle chunk index
- obs_data  in  chunkWidth  RAM data, valid exactly 1 cycle after obs_rd_en
- result_valid  out  1  result held until accepted
- result_ready  in  1  consumer accept
- result_collide  out  agentNum  bit i = channel i hit any obstacle cell
- result_first_hit  out  agentNum*beatW  first beat index with a hit per channel; 0 when no hit
- busy  out  1  state != IDLE

Behaviour:
- One clock CLK; RST is synchronous and active-high. All state is updated on the CLK rising edge.
- Reset values:
  - state = IDLE, beat counter = 0.
  - start_ready = 1 after the reset cycle.
  - agent_ready, obs_rd_en, result_valid, busy = 0.
  - obs_addr, result_collide, result_first_hit = 0.
- FSM states: IDLE, RUN, DRAIN, FLUSH (feature only), DONE.
- IDLE:
  - start_valid & start_ready -> RUN.
  - Clear the beat counter, hit flags and first_hit registers.
  - agent_valid is ignored in IDLE.
- RUN:
  - agent_ready = 1. On handshake in cycle t: obs_rd_en = 1 combinationally, obs_addr = beat counter; agent_data is registered; the counter increments.
  - At t+1: hit_i = |(obs_data & agent_chunk_i).
  - When hit_i = 1 and flag_i = 0: set flag_i and capture first_hit_i = the beat index.
  - Stalls (agent_valid = 0) insert bubbles with no read and no accumulate.
- Last beat handshake (counter = beatNum-1) -> DRAIN; the counter wraps to 0 and is not reused.
- DRAIN: one cycle for the final accumulate, then DONE.
- DONE:
  - result_valid = 1; results are stable while held.
  - result_valid & result_ready -> IDLE. start_ready rises the following cycle, so there is no same-cycle restart.
- Latency: result_valid is asserted 2 cycles after the last beat handshake, excluding any result_ready wait.
- result_first_hit never changes after the first capture in a pass.
- RST mid-pass: return to IDLE in the next cycle; discard the partial pass; any in-flight RAM read data is ignored.
- obs_data is sampled only in the cycle after an obs_rd_en.

Optional Feature:
- Macro: COLLIDE_EARLY_EXIT_EN.
- With the macro: when all agentNum flags are set after an accumulate and beats remain, RUN -> FLUSH.
  - FLUSH keeps agent_ready = 1 and consumes the remaining beats with obs_rd_en held 0.
  - After the last beat -> DRAIN -> DONE; result timing is unchanged.
  - The goal is RAM read power saving.
- Without the macro: FLUSH does not exist, and every beat issues a read.

Decomposition:
- Shared package collide_pkg:
  - FSM state encoding.
  - clog2 function.
  - Default grid/chunk/agent constants shared with the pose generator.
- Natural sub-module: collide_chunk_acc.
  - Per-channel AND-reduce, sticky flag and first_hit capture.
  - Instantiated agentNum times via generate.

Test Plan (bench override: gridWidth=64, chunkWidth=16, agentNum=2, beatNum=4):
1. No collision:
   - Stimulus: obstacle = 0xFFFF in every chunk; agent beats = 0 on both channels; result_ready held high.
   - Required: result_collide=2'b00 and first_hit=0 for both channels.
   - Required: result_valid exactly 2 cycles after beat 3's handshake, then start_ready=1 one cycle later.
2. Single-cell hit:
   - Stimulus: obstacle chunk2 = 0x0010; ch1 beat2 = 0x0010; everything else 0.
   - Required: result_collide=2'b10; first_hit ch1=2; ch0 collide=0.
3. Multiple hits:
   - Stimulus: ch0 hits at beats 1 and 3.
   - Required: first_hit ch0=1; collide bit0=1.
4. Backpressure:
   - Stimulus: agent_valid toggles 1/0 every cycle; result_ready delayed 5 cycles.
   - Required: obs_rd_en count = 4 and results equal to the unstalled run.
   - Required: result_valid stays high and results stay stable for all 5 cycles.
5. Reset mid-pass:
   - Stimulus: RST=1 for 1 cycle after beat 1's handshake.
   - Required: next cycle busy=0, start_ready=1, result_valid=0; a new pass runs cleanly.
6. COLLIDE_EARLY_EXIT_EN:
   - Stimulus: both channels hit at beat 0.
   - Required: obs_rd_en pulses = 1 and all 4 agent beats accepted.
   - Required: result_collide=2'b11 and first_hit = 0/0.
   - Required: without the macro, the same stimulus gives obs_rd_en pulses = 4.

Source files
------------

// File: rtl/collide_pkg.sv
// collide_pkg -- shared definitions for the streaming collision checker.
//
// Holds the default grid geometry (shared with the pose generator), the FSM
// state encoding used by collide_stream and a constant clog2 helper used to
// size the beat counter.
package collide_pkg;

   // Default geometry: 65536-cell grid streamed as 512-bit beats, 4 poses.
   localparam int GRID_WIDTH  = 65536;
   localparam int CHUNK_WIDTH = 512;
   localparam int AGENT_NUM   = 4;

   // FSM state encoding. FLUSH is only reachable with early exit enabled.
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RUN   = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] FLUSH = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/collide_chunk_acc.sv
// collide_chunk_acc -- one footprint channel of the collision checker.
//
// ANDs the registered agent chunk against the obstacle chunk returned by the
// RAM, keeps a sticky hit flag and captures the index of the first colliding
// beat. The capture is locked once the flag is set.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   clr          clear flag and first_hit at the start of a pass
//   acc_en       obs_chunk/agent_chunk/beat_idx are valid this cycle
//   obs_chunk    obstacle RAM data for the beat
//   agent_chunk  registered footprint chunk for this channel
//   beat_idx     beat index belonging to the data
//   flag         sticky collide flag
//   flag_next    flag including this cycle's accumulate (early-exit detect)
//   first_hit    first beat index with a hit; 0 while no hit
module collide_chunk_acc
   import collide_pkg::*;
#(
   parameter int chunkWidth = CHUNK_WIDTH,
   parameter int beatW      = 1
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  clr,
   input  logic                  acc_en,
   input  logic [chunkWidth-1:0] obs_chunk,
   input  logic [chunkWidth-1:0] agent_chunk,
   input  logic [beatW-1:0]      beat_idx,
   output logic                  flag,
   output logic                  flag_next,
   output logic [beatW-1:0]      first_hit
);

   logic hit;

   assign hit       = |(obs_chunk & agent_chunk);
   assign flag_next = flag | (acc_en & hit);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         flag      <= 1'b0;
         first_hit <= '0;
      end else if (acc_en && hit && !flag) begin
         // Only the first hit of a pass is captured; later hits leave it alone.
         flag      <= 1'b1;
         first_hit <= beat_idx;
      end
   end

endmodule

// File: rtl/collide_stream.sv
// collide_stream -- streaming multi-channel grid collision checker.
//
// Accepts agentNum footprints one chunkWidth-bit beat at a time, reads the
// matching obstacle chunk from external RAM (1-cycle read latency) and ANDs
// them per channel. Reports a sticky per-channel collide flag and the first
// colliding beat index once all beatNum beats have been consumed.
//
// Optional feature (macro COLLIDE_EARLY_EXIT_EN): once every channel has hit,
// the remaining beats are still accepted but no further RAM reads are issued.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   start_valid/ready start a pass (ready only in IDLE)
//   agent_valid/ready agent beat handshake (ready in RUN/FLUSH)
//   agent_data        channel i at [i*chunkWidth +: chunkWidth]
//   obs_rd_en/addr    obstacle RAM read strobe and chunk index
//   obs_data          RAM data, valid the cycle after obs_rd_en
//   result_valid/ready result handshake; results held until accepted
//   result_collide    bit i = channel i hit an obstacle
//   result_first_hit  channel i at [i*beatW +: beatW]; 0 when no hit
//   busy              state != IDLE
module collide_stream
   import collide_pkg::*;
#(
   parameter  int gridWidth  = GRID_WIDTH,
   parameter  int chunkWidth = CHUNK_WIDTH,
   parameter  int agentNum   = AGENT_NUM,
   localparam int beatNum    = gridWidth / chunkWidth,
   localparam int beatW      = clog2(beatNum)
)(
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         start_valid,
   output logic                         start_ready,
   input  logic                         agent_valid,
   output logic                         agent_ready,
   input  logic [agentNum*chunkWidth-1:0] agent_data,
   output logic                         obs_rd_en,
   output logic [beatW-1:0]             obs_addr,
   input  logic [chunkWidth-1:0]        obs_data,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic [agentNum-1:0]          result_collide,
   output logic [agentNum*beatW-1:0]    result_first_hit,
   output logic                         busy
);

   localparam logic [beatW-1:0] lastBeat = beatW'(beatNum - 1);

   logic [2:0]                    state;
   logic [2:0]                    state_next;
   logic [beatW-1:0]              cnt;
   logic [agentNum*chunkWidth-1:0] agent_q;
   logic [beatW-1:0]              beat_q;
   logic                          acc_en_q;
   logic [agentNum-1:0]           flag_next;
   logic                          all_hit_next;
   logic                          start_hs;
   logic                          agent_hs;
   logic                          last_hs;

   assign start_ready  = (state == IDLE);
   assign agent_ready  = (state == RUN) || (state == FLUSH);
   assign result_valid = (state == DONE);
   assign busy         = (state != IDLE);

   assign start_hs = start_valid && start_ready;
   assign agent_hs = agent_valid && agent_ready;
   assign last_hs  = agent_hs && (cnt == lastBeat);

   assign obs_addr     = cnt;
   assign all_hit_next = &flag_next;

`ifdef COLLIDE_EARLY_EXIT_EN
   // The accumulate of the previous beat is visible combinationally, so a beat
   // accepted in the same cycle that completes the hit set is already skipped.
   assign obs_rd_en = agent_hs && (state == RUN) && !all_hit_next;
`else
   assign obs_rd_en = agent_hs && (state == RUN);
   // Reduced flags only steer the early-exit path; keep them referenced here.
   logic unused_all_hit;
   assign unused_all_hit = all_hit_next;
`endif

   // NOTE: every branch of a combinational block must assign its outputs;
   // the default assignment at the top prevents an inferred latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start_hs) state_next = RUN;
         RUN: begin
            if (last_hs) state_next = DRAIN;
`ifdef COLLIDE_EARLY_EXIT_EN
            else if (all_hit_next) state_next = FLUSH;
`endif
         end
`ifdef COLLIDE_EARLY_EXIT_EN
         FLUSH: if (last_hs) state_next = DRAIN;
`endif
         DRAIN: state_next = DONE;
         DONE:  if (result_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_en_q <= 1'b0;   // drops any read that is still in flight
      end else begin
         state    <= state_next;
         acc_en_q <= obs_rd_en;
         if (start_hs)      cnt <= '0;
         else if (last_hs)  cnt <= '0;
         else if (agent_hs) cnt <= cnt + 1'b1;
      end
   end

   // NOTE: pure datapath registers carry no reset; they are only consumed when
   // acc_en_q (which is reset) marks them valid.
   always_ff @(posedge CLK) begin
      if (obs_rd_en) begin
         agent_q <= agent_data;
         beat_q  <= cnt;
      end
   end

   for (genvar i = 0; i < agentNum; i++) begin : g_chan
      collide_chunk_acc #(
         .chunkWidth (chunkWidth),
         .beatW      (beatW)
      ) u_acc (
         .CLK         (CLK),
         .RST         (RST),
         .clr         (start_hs),
         .acc_en      (acc_en_q),
         .obs_chunk   (obs_data),
         .agent_chunk (agent_q[i*chunkWidth +: chunkWidth]),
         .beat_idx    (beat_q),
         .flag        (result_collide[i]),
         .flag_next   (flag_next[i]),
         .first_hit   (result_first_hit[i*beatW +: beatW])
      );
   end

endmodule

// File: tb/tb_collide_stream.sv
// tb_collide_stream -- self-checking bench for collide_stream.
// Small geometry: 64-bit grid, 16-bit beats, 2 channels, 4 beats.
// Expected results come from a reference model of the grid check and are
// queued when a pass is launched, then popped when the DUT presents a result.
module tb_collide_stream;

   localparam int GW = 64;
   localparam int CW = 16;
   localparam int AN = 2;
   localparam int BN = 4;
   localparam int BW = 2;

   typedef struct packed {
      logic [AN-1:0]    collide;
      logic [AN*BW-1:0] first_hit;
      logic [2:0]       reads;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              start_valid = 1'b0;
   logic              start_ready;
   logic              agent_valid = 1'b0;
   logic              agent_ready;
   logic [AN*CW-1:0]  agent_data = '0;
   logic              obs_rd_en;
   logic [BW-1:0]     obs_addr;
   logic [CW-1:0]     obs_data = '0;
   logic              result_valid;
   logic              result_ready = 1'b0;
   logic [AN-1:0]     result_collide;
   logic [AN*BW-1:0]  result_first_hit;
   logic              busy;

   logic [CW-1:0] obs_mem [BN];
   logic [CW-1:0] ag [BN][AN];

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rd_cnt   = 0;
   int acc_cnt  = 0;
   int last_hs_cyc = 0;
   int rv_cyc   = 0;
   bit rv_seen  = 1'b0;

   collide_stream #(
      .gridWidth  (GW),
      .chunkWidth (CW),
      .agentNum   (AN)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .start_valid      (start_valid),
      .start_ready      (start_ready),
      .agent_valid      (agent_valid),
      .agent_ready      (agent_ready),
      .agent_data       (agent_data),
      .obs_rd_en        (obs_rd_en),
      .obs_addr         (obs_addr),
      .obs_data         (obs_data),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result_collide   (result_collide),
      .result_first_hit (result_first_hit),
      .busy             (busy)
   );

   always #5 CLK = ~CLK;

   // Obstacle RAM: data valid one cycle after the strobe, junk otherwise.
   always @(posedge CLK) begin
      if (obs_rd_en) obs_data <= obs_mem[obs_addr];
      else           obs_data <= 16'($urandom);
   end

   // Edge monitor: read strobes, beat handshakes, first result_valid.
   always @(posedge CLK) begin
      cyc++;
      if (!RST) begin
         if (obs_rd_en) rd_cnt++;
         if (agent_valid && agent_ready) begin
            acc_cnt++;
            last_hs_cyc = cyc;
         end
         if (result_valid && !rv_seen) begin
            rv_seen = 1'b1;
            rv_cyc  = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_pattern(input logic [CW-1:0] fill);
      for (int b = 0; b < BN; b++) begin
         obs_mem[b] = fill;
         ag[b][0]   = '0;
         ag[b][1]   = '0;
      end
   endtask

   // Reference: first beat whose footprint overlaps an obstacle, per channel.
   function automatic exp_t model();
      exp_t e;
      int   last;
      e = '0;
      for (int ch = 0; ch < AN; ch++)
         for (int b = 0; b < BN; b++)
            if (!e.collide[ch] && (|(obs_mem[b] & ag[b][ch]))) begin
               e.collide[ch] = 1'b1;
               e.first_hit[ch*BW +: BW] = BW'(b);
            end
      e.reads = 3'd4;
`ifdef COLLIDE_EARLY_EXIT_EN
      // Reads stop right after the beat that completes the hit set.
      if (&e.collide) begin
         last = 0;
         for (int ch = 0; ch < AN; ch++)
            if (int'(e.first_hit[ch*BW +: BW]) > last) last = int'(e.first_hit[ch*BW +: BW]);
         e.reads = 3'(last + 1);
      end
`else
      last = 0;
`endif
      return e;
   endfunction

   task automatic run_pass(input string name, input bit toggle, input int delay);
      exp_t e;
      int   beat;
      int   guard;
      bit   hs;
      sb.push_back(model());
      rd_cnt  = 0;
      acc_cnt = 0;
      rv_seen = 1'b0;
      result_ready = (delay == 0);
      guard = 0;
      while (!start_ready && guard < 20) begin
         tick();
         guard++;
      end
      check({name, "/start_ready_idle"}, 32'(start_ready), 32'd1);
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      beat  = 0;
      guard = 0;
      while (beat < BN && guard < 64) begin
         agent_valid = toggle ? (guard % 2 == 0) : 1'b1;
         agent_data  = {ag[beat][1], ag[beat][0]};
         hs = agent_valid && agent_ready;
         tick();
         if (hs) beat++;
         guard++;
      end
      agent_valid = 1'b0;
      agent_data  = '0;
      check({name, "/beats_accepted"}, 32'(beat), 32'(BN));
      guard = 0;
      while (!result_valid && guard < 20) begin
         tick();
         guard++;
      end
      check({name, "/result_valid"}, 32'(result_valid), 32'd1);
      e = sb.pop_front();
      for (int d = 0; d < delay; d++) begin
         check({name, "/hold_valid"}, 32'(result_valid), 32'd1);
         check({name, "/hold_collide"}, 32'(result_collide), 32'(e.collide));
         check({name, "/hold_first_hit"}, 32'(result_first_hit), 32'(e.first_hit));
         tick();
      end
      result_ready = 1'b1;
      check({name, "/collide"}, 32'(result_collide), 32'(e.collide));
      check({name, "/first_hit"}, 32'(result_first_hit), 32'(e.first_hit));
      check({name, "/no_same_cycle_restart"}, 32'(start_ready), 32'd0);
      tick();
      result_ready = 1'b0;
      check({name, "/start_ready_after"}, 32'(start_ready), 32'd1);
      check({name, "/busy_after"}, 32'(busy), 32'd0);
      check({name, "/valid_dropped"}, 32'(result_valid), 32'd0);
      check({name, "/latency"}, 32'(rv_cyc - last_hs_cyc), 32'd2);
      check({name, "/rd_count"}, 32'(rd_cnt), 32'(e.reads));
      check({name, "/hs_count"}, 32'(acc_cnt), 32'(BN));
   endtask

   initial begin
      clear_pattern('0);
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;

      check("reset/start_ready", 32'(start_ready), 32'd1);
      check("reset/agent_ready", 32'(agent_ready), 32'd0);
      check("reset/obs_rd_en", 32'(obs_rd_en), 32'd0);
      check("reset/result_valid", 32'(result_valid), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/obs_addr", 32'(obs_addr), 32'd0);
      check("reset/collide", 32'(result_collide), 32'd0);
      check("reset/first_hit", 32'(result_first_hit), 32'd0);

      // 1: obstacles everywhere, empty footprints.
      clear_pattern(16'hFFFF);
      run_pass("no_hit", 1'b0, 0);

      // 2: single cell hit on channel 1 at beat 2.
      clear_pattern('0);
      obs_mem[2] = 16'h0010;
      ag[2][1]   = 16'h0010;
      run_pass("single_hit", 1'b0, 0);

      // 4: same stimulus with a stalling source and a slow consumer.
      run_pass("backpressure", 1'b1, 5);

      // 3: channel 0 hits at beats 1 and 3; first capture must stick.
      clear_pattern(16'hFFFF);
      ag[1][0] = 16'h0001;
      ag[3][0] = 16'h8000;
      run_pass("multi_hit", 1'b0, 0);

      // Hit only on the last beat.
      clear_pattern(16'h00F0);
      ag[3][1] = 16'h0080;
      ag[2][0] = 16'h0F00;
      run_pass("last_beat_hit", 1'b1, 2);

      // 5: reset after beat 1's handshake; beat 0 already hit, beat 1 in flight.
      clear_pattern(16'hFFFF);
      ag[0][0] = 16'h0001;
      ag[1][1] = 16'h0002;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         agent_valid = 1'b1;
         agent_data  = {ag[b][1], ag[b][0]};
         tick();
      end
      agent_valid = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("midreset/busy", 32'(busy), 32'd0);
      check("midreset/start_ready", 32'(start_ready), 32'd1);
      check("midreset/result_valid", 32'(result_valid), 32'd0);
      check("midreset/collide", 32'(result_collide), 32'd0);
      tick();
      check("midreset/collide_settled", 32'(result_collide), 32'd0);
      clear_pattern(16'hFFFF);
      ag[1][0] = 16'h0001;
      ag[3][0] = 16'h8000;
      run_pass("after_reset", 1'b0, 0);

      // 6: both channels hit at beat 0 (later hits too).
      clear_pattern(16'hFFFF);
      ag[0][0] = 16'h0001;
      ag[0][1] = 16'h0002;
      ag[2][0] = 16'h0100;
      run_pass("all_hit_beat0", 1'b0, 0);

      // All channels complete at beat 2 with a stalling source.
      clear_pattern(16'h0FF0);
      ag[1][0] = 16'h0010;
      ag[2][1] = 16'h0800;
      ag[3][0] = 16'h0020;
      run_pass("all_hit_beat2", 1'b1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
